// File: rtl/writeback_port_arbiter_if.sv
// Writeback arbiter bus: execute-result and load-response requesters on one side,
// the registered register-file write port on the other.
// master: requester/register-file side, slave: the arbiter.
interface writeback_port_arbiter_if #(
  parameter int XLEN = 32
);
  logic            alu_wb_valid;
  logic            alu_wb_ready;
  logic [1:0]      alu_wb_sel;
  logic [4:0]      alu_wb_rd;
  logic [XLEN-1:0] alu_wb_data;
  logic [XLEN-1:0] alu_wb_pc;
  logic            dm_rsp_valid;
  logic            dm_rsp_ready;
  logic [4:0]      dm_rsp_rd;
  logic [XLEN-1:0] dm_rsp_data;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            wb_sel_err;

  modport master (
    output alu_wb_valid, alu_wb_sel, alu_wb_rd, alu_wb_data, alu_wb_pc,
    output dm_rsp_valid, dm_rsp_rd, dm_rsp_data,
    input  alu_wb_ready, dm_rsp_ready, rf_we, rf_waddr, rf_wdata, wb_sel_err
  );

  modport slave (
    input  alu_wb_valid, alu_wb_sel, alu_wb_rd, alu_wb_data, alu_wb_pc,
    input  dm_rsp_valid, dm_rsp_rd, dm_rsp_data,
    output alu_wb_ready, dm_rsp_ready, rf_we, rf_waddr, rf_wdata, wb_sel_err
  );
endinterface

// File: rtl/writeback_port_arbiter.sv
// Register-file write port arbiter: loads win by default, execute results are
// buffered in a small FIFO and protected from starvation by a bounded counter.
// Optional feature macro: WB_BYPASS_EN (execute result granted in its accept cycle
// when the FIFO is empty and no load is granted).
module writeback_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  writeback_port_arbiter_if.slave wb
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);
  localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    SEL_ALU  = 2'd0,
    SEL_RSV1 = 2'd1,
    SEL_PC   = 2'd2,
    SEL_RSV3 = 2'd3
  } wb_sel_e;

  // Link values are resolved at accept time so the FIFO holds final write data.
  typedef struct packed {
    wb_sel_e         sel;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  wb_entry_t       mem_q [FIFO_DEPTH];
  wb_entry_t       mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            sel_err_q, sel_err_d;

  logic      fifo_ne, alu_ready, accept, starved;
  logic      grant_load, grant_exe, grant_byp, granted, legal;
  logic      push, pop;
  wb_entry_t in_entry, win;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  // Grant decision, FIFO bookkeeping and next write-port values.
  always_comb begin
    fifo_ne   = (count_q != '0);
    alu_ready = (count_q < DEPTH_C);
    accept    = wb.alu_wb_valid && alu_ready;
    starved   = fifo_ne && (starve_q == LIMIT_C);

    in_entry.sel  = wb_sel_e'(wb.alu_wb_sel);
    in_entry.rd   = wb.alu_wb_rd;
    in_entry.data = (in_entry.sel == SEL_PC) ? (wb.alu_wb_pc + XLEN'(4)) : wb.alu_wb_data;

    grant_load = rst_n && !starved && wb.dm_rsp_valid;
    grant_exe  = rst_n && fifo_ne && !grant_load;
    grant_byp  = 1'b0;
`ifdef WB_BYPASS_EN
    grant_byp  = rst_n && !fifo_ne && !grant_load && accept;
`else
    grant_byp  = 1'b0;
`endif
    granted = grant_load || grant_exe || grant_byp;

    push = rst_n && accept && !grant_byp;
    pop  = grant_exe;

    if (grant_load) begin
      win.sel  = SEL_ALU;
      win.rd   = wb.dm_rsp_rd;
      win.data = wb.dm_rsp_data;
    end else if (grant_exe) begin
      win = mem_q[rd_ptr_q];
    end else begin
      win = in_entry;
    end
    legal = (win.sel == SEL_ALU) || (win.sel == SEL_PC);

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = in_entry;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    starve_d = starve_q;
    if (!fifo_ne || grant_exe)                    starve_d = '0;
    else if (grant_load && (starve_q != LIMIT_C)) starve_d = starve_q + SW'(1);

    rf_we_d    = granted && legal && (win.rd != 5'd0);
    sel_err_d  = granted && !legal;
    rf_waddr_d = granted ? win.rd   : rf_waddr_q;
    rf_wdata_d = granted ? win.data : rf_wdata_q;
  end

  // Control state and registered write port, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      sel_err_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      sel_err_q  <= sel_err_d;
    end
  end

  // FIFO storage; contents are don't-care while count is zero, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign wb.alu_wb_ready = alu_ready;
  assign wb.dm_rsp_ready = grant_load;
  assign wb.rf_we        = rf_we_q;
  assign wb.rf_waddr     = rf_waddr_q;
  assign wb.rf_wdata     = rf_wdata_q;
  assign wb.wb_sel_err   = sel_err_q;

endmodule
